tile_fetch: RTL and testbench
=============================

# tile_fetch

Instruction fetch stage for a mesh tile. It holds the tile's program in a 32-entry instruction store and steps a 5-bit program counter through it. Each fetched 15-bit instruction is presented to the downstream decode/execute stage over a valid/ready handshake, with the opcode, location and word fields pre-split. Supports program load, run/stop, wrap-around at a programmable last address, and jump redirection with flush.

## Interface
Parameters:
- PROG_DEPTH, 32, instruction store entries; must be ≤ 32 (address type is 5 bits).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- nrst  in  1  reset. Asynchronous and active-high: nrst=1 resets immediately, independent of clk.
- load_en  in  1  write strobe into the instruction store; honoured only in IDLE.
- load_addr  in  5  store write address; writes at addresses ≥ PROG_DEPTH are dropped.
- load_data  in  15  instruction to write.
- prog_last  in  5  address of the final program instruction; the PC wraps to 0 after it.
- run  in  1  level; 1 = fetch, 0 = stop.
- jump_valid  in  1  redirect request, one cycle.
- jump_addr  in  5  redirect target.
- out_valid  out  1  output holds an instruction.
- out_ready  in  1  downstream accepts the instruction.
- out_instr  out  15  fetched instruction.
- out_opcode  out  4  out_instr[14:11].
- out_location  out  3  out_instr[10:8].
- out_word  out  8  out_instr[7:0].
- out_pc  out  5  address out_instr was fetched from.

## Operation
- State machine, 2 states:
  - IDLE: no fetching; program loads accepted.
  - RUN: fetching.
- Transitions:
  - IDLE→RUN when run=1 and load_en=0.
  - RUN→IDLE when run=0.
- Stopping does not drop the current output. out_valid stays high until that instruction is accepted. The PC is preserved, so a later run=1 resumes where fetch stopped.
- Store: PROG_DEPTH×15 flops, read combinationally at pc.
- fire = (state==RUN) & run & ~jump_valid & (~out_valid | out_ready).
- On fire:
  - out_instr ← mem[pc], out_pc ← pc, out_valid ← 1.
  - pc ← (pc==prog_last) ? 0 : pc+1. Increment is 5-bit modulo; a prog_last ≥ PROG_DEPTH also wraps at PROG_DEPTH−1.
- On accept without a new fire (out_valid & out_ready & ~fire): out_valid ← 0.
- Jump (jump_valid=1, any state):
  - pc ← jump_addr; out_valid ← 0 (flush).
  - No fetch occurs that cycle.
  - If out_valid & out_ready in the same cycle, the transfer counts as completed.
- Output stability: while out_valid & ~out_ready, all out_* fields are held constant.
- load_en in RUN is ignored; no store change.
- Simultaneous run=1 and load_en=1 in IDLE: the write happens and the state stays IDLE.

## Timing
- Reset values:
  - state=IDLE, pc=0, out_valid=0.
  - out_instr=0, so out_opcode=0, out_location=0, out_word=0; out_pc=0.
  - All store entries = 0.
- Reset mid-operation clears everything above at once, including an un-accepted output.
- Startup latency: run sampled 1 at edge N moves to RUN. The first fire is at edge N+1, so out_valid is high after edge N+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Jump latency: jump at edge N; mem[jump_addr] is presented after edge N+1.
- A store write at edge N is visible to a fetch at edge N+1 or later.

## Test plan
- Reset/load:
  - Assert nrst mid-cycle → all outputs go to 0 before the next clk edge.
  - Load addr0=0x1A05, addr1=0x0123, addr2=0x7FFF; prog_last=2; run=1, out_ready=1 → out_instr 0x1A05, 0x0123, 0x7FFF, 0x1A05… with out_pc 0,1,2,0. For 0x1A05: opcode=3, location=2, word=0x05.
- Backpressure: out_ready=0 for 4 cycles while running → out_valid=1 and out_instr/out_pc constant. Release → no instruction skipped or duplicated.
- Jump: jump_valid with jump_addr=1 while out_valid=1, out_ready=0 → out_valid=0 next cycle; the following cycle gives out_instr=0x0123, out_pc=1.
- Stop/resume:
  - Drop run while holding pc=2 with out_ready=0 → output retained, no further fetch after accept.
  - run=1 again → next out_pc=0 (wrapped from pc=2).
- Load guard: load_en in RUN writing 0x7777 to addr0 → store unchanged, so out_instr at out_pc 0 remains 0x1A05.

Source files
------------

// File: rtl/tile_fetch.sv
// Instruction fetch stage for a mesh tile: 32-entry program store, 5-bit PC,
// valid/ready output with pre-split opcode/location/word fields and jump flush.
module tile_fetch #(
  parameter int PROG_DEPTH = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        load_en,
  input  logic [4:0]  load_addr,
  input  logic [14:0] load_data,
  input  logic [4:0]  prog_last,
  input  logic        run,
  input  logic        jump_valid,
  input  logic [4:0]  jump_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_instr,
  output logic [3:0]  out_opcode,
  output logic [2:0]  out_location,
  output logic [7:0]  out_word,
  output logic [4:0]  out_pc
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] LAST_IDX = 5'(PROG_DEPTH - 1);

  state_t      state, state_nxt;
  logic [14:0] mem [PROG_DEPTH];
  logic [4:0]  pc;
  logic [4:0]  pc_nxt;
  logic [14:0] rd_data;
  logic        fire;
  logic        wr_en;

  function automatic logic [4:0] next_pc(input logic [4:0] cur, input logic [4:0] last);
    if (cur == last || cur == LAST_IDX) return 5'd0;
    return cur + 5'd1;
  endfunction

  // Out-of-range reads (possible via jump when PROG_DEPTH < 32) return a zero word.
  always_comb begin
    rd_data = '0;
    if (int'(pc) < PROG_DEPTH) rd_data = mem[pc];
  end

  assign fire   = (state == RUN) && run && !jump_valid && (!out_valid || out_ready);
  assign wr_en  = (state == IDLE) && load_en && (int'(load_addr) < PROG_DEPTH);
  assign pc_nxt = next_pc(pc, prog_last);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (run && !load_en) state_nxt = RUN;
      RUN:  if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Fetch stage boundary: PC and the registered output slot.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      pc        <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (jump_valid) begin
      pc        <= jump_addr;
      out_valid <= 1'b0;
    end else if (fire) begin
      out_instr <= rd_data;
      out_pc    <= pc;
      out_valid <= 1'b1;
      pc        <= pc_nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_opcode   = out_instr[14:11];
  assign out_location = out_instr[10:8];
  assign out_word     = out_instr[7:0];

endmodule

// File: tb/tb_tile_fetch.sv
// Directed bench for tile_fetch: reset, load, streaming, backpressure, jump,
// stop/resume, load guard and asynchronous mid-run reset.
module tb_tile_fetch;

  logic        clk = 1'b0;
  logic        nrst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [14:0] load_data;
  logic [4:0]  prog_last;
  logic        run;
  logic        jump_valid;
  logic [4:0]  jump_addr;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_instr;
  logic [3:0]  out_opcode;
  logic [2:0]  out_location;
  logic [7:0]  out_word;
  logic [4:0]  out_pc;

  int total = 0;
  int passed = 0;

  tile_fetch #(.PROG_DEPTH(32)) dut (
    .clk(clk), .nrst(nrst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_last(prog_last), .run(run),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_opcode(out_opcode),
    .out_location(out_location), .out_word(out_word), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [14:0] instr, input logic [4:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, 32'(out_instr), 32'(instr));
    chk({tag, "_pc"},    32'(out_pc),    32'(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_last = 5'd2; run = 1'b0; jump_valid = 1'b0; jump_addr = '0;
    out_ready = 1'b0;
    #1 nrst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_pc",    32'(out_pc),    32'd0);
    step(); step();
    nrst = 1'b0;

    load_en = 1'b1; load_addr = 5'd0; load_data = 15'h1A05; step();
    load_addr = 5'd1; load_data = 15'h0123; step();
    load_addr = 5'd2; load_data = 15'h7FFF; run = 1'b1; step();
    chk("idle_with_load", 32'(out_valid), 32'd0);
    load_en = 1'b0; out_ready = 1'b1; step();
    chk("startup_latency", 32'(out_valid), 32'd0);
    step(); chk_out("s0", 15'h1A05, 5'd0);
    chk("opcode",   32'(out_opcode),   32'd3);
    chk("location", 32'(out_location), 32'd2);
    chk("word",     32'(out_word),     32'h05);
    step(); chk_out("s1", 15'h0123, 5'd1);
    step(); chk_out("s2", 15'h7FFF, 5'd2);
    step(); chk_out("wrap", 15'h1A05, 5'd0);
    step(); chk_out("s4", 15'h0123, 5'd1);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_out("bp_hold", 15'h0123, 5'd1);
    end
    out_ready = 1'b1; step(); chk_out("bp_release", 15'h7FFF, 5'd2);
    out_ready = 1'b0; step(); chk_out("bp_hold2", 15'h7FFF, 5'd2);

    jump_valid = 1'b1; jump_addr = 5'd1; step();
    chk("jump_flush", 32'(out_valid), 32'd0);
    jump_valid = 1'b0; out_ready = 1'b1; step(); chk_out("jump_tgt", 15'h0123, 5'd1);
    step(); chk_out("jump_next", 15'h7FFF, 5'd2);

    run = 1'b0; out_ready = 1'b0; step(); chk_out("stop_hold", 15'h7FFF, 5'd2);
    step(); chk_out("stop_hold2", 15'h7FFF, 5'd2);
    out_ready = 1'b1; step();
    chk("stop_accept", 32'(out_valid), 32'd0);
    step();
    chk("stop_nofetch", 32'(out_valid), 32'd0);

    run = 1'b1; step();
    chk("resume_latency", 32'(out_valid), 32'd0);
    load_en = 1'b1; load_addr = 5'd0; load_data = 15'h7777; step();
    chk_out("resume_wrap", 15'h1A05, 5'd0);
    load_en = 1'b0; step(); chk_out("g1", 15'h0123, 5'd1);
    step(); chk_out("g2", 15'h7FFF, 5'd2);
    step(); chk_out("load_guard", 15'h1A05, 5'd0);
    step(); chk_out("g4", 15'h0123, 5'd1);

    #2 nrst = 1'b1;
    #1;
    chk("arst_valid",  32'(out_valid),  32'd0);
    chk("arst_instr",  32'(out_instr),  32'd0);
    chk("arst_opcode", 32'(out_opcode), 32'd0);
    chk("arst_pc",     32'(out_pc),     32'd0);
    step();
    nrst = 1'b0;
    step();
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    step(); chk_out("mem_cleared", 15'h0000, 5'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
